// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Define APB_TIMEOUT_EN to bound ACCESS-phase waits to TIMEOUT_CYCLES (completes with slave error).
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
  input  logic [NUM_REQ*3-1:0]          req_prot,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_slverr,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [ADDR_W-1:0]             PADDR,
  output logic                          PWRITE,
  output logic [DATA_W-1:0]             PWDATA,
  output logic [DATA_W/8-1:0]           PSTRB,
  output logic [2:0]                    PPROT,
  input  logic [DATA_W-1:0]             PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);
  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, win;
  logic                found, accept, done, timeout;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q, slverr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [SW-1:0]       strb_q;
  logic [2:0]          prot_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_arbiter: parameter out of range");
  end
  // ptr_q doubles as the in-flight requester index: the last winner is the one on the bus
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[IW'((int'(ptr_q) + k) % NUM_REQ)]) begin
        win   = IW'((int'(ptr_q) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign accept = PRESETn && state_q == IDLE && found;
  assign done   = state_q == ACCESS && (PREADY || timeout);
  always_comb begin
    state_d = accept ? SETUP : state_q == SETUP ? ACCESS : done ? IDLE : state_q;
  end
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign timeout = state_q == ACCESS && !PREADY && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= state_q == ACCESS ? cnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done ? NUM_REQ'(1) << ptr_q : '0;
      if (accept) begin
        ptr_q   <= win;
        addr_q  <= req_addr[win*ADDR_W +: ADDR_W];
        write_q <= req_write[win];
        wdata_q <= req_wdata[win*DATA_W +: DATA_W];
        strb_q  <= req_strb[win*SW +: SW];
        prot_q  <= req_prot[win*3 +: 3];
      end
      if (done) begin
        rdata_q  <= (write_q || timeout) ? '0 : PRDATA;
        slverr_q <= timeout || PSLVERR;
      end
    end
  end
  assign req_ready  = accept ? NUM_REQ'(1) << win : '0;
  assign PSEL       = state_q != IDLE;
  assign PENABLE    = state_q == ACCESS;
  assign PADDR      = addr_q;
  assign PWRITE     = write_q;
  assign PWDATA     = wdata_q;
  assign PSTRB      = write_q ? strb_q : '0;
  assign PPROT      = prot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_slverr = slverr_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scenarios plus random traffic against a transfer-level reference model.
module tb_apb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
  logic            PCLK, PRESETn;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*3-1:0]  req_prot;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic            rsp_slverr, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]   PADDR;
  logic [SW-1:0]   PSTRB;
  logic [2:0]      PPROT;
  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR));
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  int checks = 0, errs = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction
  // reference model: one transfer in flight, tracked by phase count since acceptance
  int cyc = 0, phase, cur, last, rsp_idx, acc_cyc, rsp_cyc, pen_run, pen_last;
  bit busy, rsp_pend;
  logic [N-1:0]  ready_s;
  logic [AW-1:0] e_addr;
  logic          e_write, e_slverr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [SW-1:0] e_strb;
  logic [2:0]    e_prot;
  int grants[$], rsps[$];
  always @(negedge PCLK) begin
    int w;
    bit to;
    logic [N-1:0] exp_rv, exp_rr;
    cyc++;
    ready_s = req_ready;
    if (!PRESETn) begin
      busy = 0; rsp_pend = 0; last = N - 1; pen_run = 0;
      e_addr = '0; e_write = 0; e_wdata = '0; e_strb = '0; e_prot = '0; e_rdata = '0; e_slverr = 0;
    end
    exp_rv = rsp_pend ? oh(rsp_idx) : '0;
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
    chk("rsp_slverr", 64'(rsp_slverr), 64'(e_slverr));
    chk("psel", 64'(PSEL), 64'(busy));
    chk("penable", 64'(PENABLE), 64'(busy && phase >= 2));
    chk("paddr", 64'(PADDR), 64'(e_addr));
    chk("pwrite", 64'(PWRITE), 64'(e_write));
    chk("pwdata", 64'(PWDATA), 64'(e_wdata));
    chk("pstrb", 64'(PSTRB), 64'(e_write ? e_strb : '0));
    chk("pprot", 64'(PPROT), 64'(e_prot));
    w = -1;
    if (PRESETn && !busy)
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
    exp_rr = w < 0 ? '0 : oh(w);
    chk("req_ready", 64'(req_ready), 64'(exp_rr));
    if (req_ready != '0) begin grants.push_back($clog2(req_ready)); acc_cyc = cyc; end
    if (rsp_valid != '0) begin rsps.push_back($clog2(rsp_valid)); rsp_cyc = cyc; end
    if (PENABLE) pen_run++;
    else begin
      if (pen_run > 0) pen_last = pen_run;
      pen_run = 0;
    end
    if (PRESETn) begin
`ifdef APB_TIMEOUT_EN
      to = phase - 1 >= TO;
`else
      to = 0;
`endif
      rsp_pend = 0;
      if (busy) begin
        if (phase >= 2 && (PREADY || to)) begin
          rsp_pend = 1; rsp_idx = cur; busy = 0;
          e_rdata  = (PREADY && !e_write) ? PRDATA : '0;
          e_slverr = PREADY ? PSLVERR : 1'b1;
        end else phase++;
      end else if (w >= 0) begin
        busy = 1; phase = 1; cur = w; last = w;
        e_addr = req_addr[w*AW +: AW]; e_write = req_write[w]; e_wdata = req_wdata[w*DW +: DW];
        e_strb = req_strb[w*SW +: SW]; e_prot = req_prot[w*3 +: 3];
      end
    end
  end
  bit rnd = 0;
  task automatic step();
    @(posedge PCLK);
    #1;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (ready_s[i] || $urandom_range(99) < 5) req_valid[i] = 1'b0;
        end else if ($urandom_range(99) < 30) begin
          req_valid[i] = 1'b1;
          req_write[i] = 1'($urandom());
          req_addr[i*AW +: AW] = $urandom();
          req_wdata[i*DW +: DW] = $urandom();
          req_strb[i*SW +: SW] = SW'($urandom());
          req_prot[i*3 +: 3] = 3'($urandom());
        end
      end
      PREADY  = $urandom_range(99) < 50;
      PRDATA  = $urandom();
      PSLVERR = $urandom_range(3) == 0;
    end
  endtask
  task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [2:0] p);
    int n = 0;
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d; req_strb[i*SW +: SW] = s; req_prot[i*3 +: 3] = p;
    do begin step(); n++; end while (!ready_s[i] && n < 50);
    chk("accept", 64'(ready_s[i]), 64'(1));
    req_valid[i] = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    PRESETn = 0; req_valid = 4'b0001; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; PREADY = 1; PRDATA = '0; PSLVERR = 0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    req_valid = '0;
    PRESETn = 1;
    issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0);
    chk("wr_setup", 64'({PSEL, PENABLE}), 64'(2'b10));
    chk("wr_setup_addr", 64'(PADDR), 64'(32'h10));
    chk("wr_setup_data", 64'(PWDATA), 64'(32'hDEADBEEF));
    step();
    chk("wr_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    chk("wr_access_addr", 64'(PADDR), 64'(32'h10));
    chk("wr_access_data", 64'(PWDATA), 64'(32'hDEADBEEF));
    step();
    chk("wr_rsp", 64'(rsp_valid), 64'(4'b0001));
    chk("wr_slverr", 64'(rsp_slverr), 64'(0));
    step();
    chk("wr_latency", 64'(rsp_cyc - acc_cyc), 64'(3));
    PREADY = 0; PRDATA = 32'h12345678;
    issue(2, 0, 32'h40, 32'hCAFEF00D, 4'hF, 3'd2);
    chk("rd_pstrb", 64'(PSTRB), 64'(0));
    repeat (4) step();
    PREADY = 1;
    step();
    chk("rd_rsp", 64'(rsp_valid), 64'(4'b0100));
    chk("rd_rdata", 64'(rsp_rdata), 64'(32'h12345678));
    step();
    chk("rd_penable_len", 64'(pen_last), 64'(4));
    PSLVERR = 1;
    issue(1, 1, 32'h80, 32'h0BAD0BAD, 4'h3, 3'd1);
    repeat (2) step();
    chk("err_rsp", 64'(rsp_valid), 64'(4'b0010));
    chk("err_slverr", 64'(rsp_slverr), 64'(1));
    PSLVERR = 0;
    issue(3, 1, 32'h84, 32'h600DCAFE, 4'hC, 3'd3);
    repeat (2) step();
    chk("ok_rsp", 64'(rsp_valid), 64'(4'b1000));
    chk("ok_slverr", 64'(rsp_slverr), 64'(0));
    PREADY = 0;
    issue(2, 0, 32'h90, 32'h0, 4'h0, 3'd0);
    repeat (2) step();
    chk("mid_penable", 64'(PENABLE), 64'(1));
    #2 PRESETn = 0;
    #1;
    chk("mid_rst_psel", 64'(PSEL), 64'(0));
    chk("mid_rst_penable", 64'(PENABLE), 64'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    PRESETn = 1; PREADY = 1; req_valid = 4'b1001;
    step();
    chk("post_rst_grant", 64'(ready_s), 64'(4'b0001));
    req_valid = '0;
    repeat (4) step();
    PRESETn = 0;
    step();
    PRESETn = 1;
    grants.delete(); rsps.delete();
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'($urandom()); req_addr[i*AW +: AW] = $urandom(); req_wdata[i*DW +: DW] = $urandom();
    end
    req_valid = '1;
    n = 0;
    while (grants.size() < 8 && n < 100) begin step(); n++; end
    req_valid = '0;
    repeat (4) step();
    chk("rr_count", 64'(grants.size()), 64'(8));
    chk("rr_rsp_count", 64'(rsps.size()), 64'(8));
    for (int k = 0; k < 8; k++)
      if (k < grants.size() && k < rsps.size()) begin
        chk("rr_grant", 64'(grants[k]), 64'(k % N));
        chk("rr_rsp_order", 64'(rsps[k]), 64'(grants[k]));
      end
    grants.delete();
    rnd = 1;
    repeat (3000) step();
    rnd = 0; req_valid = '0; PREADY = 1;
    repeat (10) step();
    chk("rand_traffic", 64'(grants.size() > 100), 64'(1));
`ifdef APB_TIMEOUT_EN
    PREADY = 0;
    issue(1, 0, 32'hA0, 32'h0, 4'hF, 3'd0);
    repeat (TO + 1) step();
    chk("to_rsp", 64'(rsp_valid), 64'(4'b0010));
    chk("to_slverr", 64'(rsp_slverr), 64'(1));
    chk("to_rdata", 64'(rsp_rdata), 64'(0));
    chk("to_penable", 64'(PENABLE), 64'(0));
    step();
    chk("to_penable_len", 64'(pen_last), 64'(TO));
    PREADY = 1;
    repeat (2) step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
